// File: rtl/dc_fifo_pkg.sv
// Shared token helpers and constants for both halves of the dual-clock token-ring FIFO.
// DC_TOKEN_RING_SYNC3_EN deepens the token synchroniser from 2 to 3 flops.
package dc_fifo_pkg;

   localparam int TOK_MAX_W = 64;
   localparam int TOK_RESET = 'hc;

`ifdef DC_TOKEN_RING_SYNC3_EN
   localparam int SYNC_DEPTH = 3;
`else
   localparam int SYNC_DEPTH = 2;
`endif

   // Rotate left by one within the low w bits; bits at and above w stay zero.
   function automatic logic [TOK_MAX_W-1:0] rotl1(input logic [TOK_MAX_W-1:0] x, input int w);
      logic [TOK_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < TOK_MAX_W; i++) begin
         if (i == 0)
            r[i] = x[w-1];
         else if (i < w)
            r[i] = x[i-1];
      end
      return r;
   endfunction

   // The leading bit of a two-hot token is the one-hot slot pointer.
   function automatic logic [TOK_MAX_W-1:0] ptr_from_tok(input logic [TOK_MAX_W-1:0] x, input int w);
      return rotl1(x, w) & x;
   endfunction

endpackage

// File: rtl/dc_token_ring.sv
// Two-hot token ring register that rotates left by one on each advance.
// Single-cycle update; advances only when i_adv is high, otherwise holds.
module dc_token_ring #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_adv,
   output logic [WIDTH-1:0] o_token
);

   logic [WIDTH-1:0] r_token;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_token <= RESET_VALUE;
      else if (i_adv)
         r_token <= {r_token[WIDTH-2:0], r_token[WIDTH-1]};
   end

   assign o_token = r_token;

endmodule

// File: rtl/dc_token_synchronizer.sv
// Multi-flop synchroniser for a token/pointer bus crossing into clk; DEPTH edges of latency.
// No handshake: the token encoding tolerates per-bit skew, so each bit is synchronised independently.
module dc_token_synchronizer #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++)
            r_stage[i] <= RESET_VALUE;
      end else begin
         r_stage[0] <= i_async;
         for (int i = 1; i < DEPTH; i++)
            r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/dc_token_ring_fifo_dout.sv
// Read half of the dual-clock token-ring FIFO: write-token sync, empty detect, valid/ready output register.
// Write-to-valid latency SYNC_DEPTH+1 edges (DC_TOKEN_RING_SYNC3_EN selects 3-flop sync); data holds while ~ready.
module dc_token_ring_fifo_dout
   import dc_fifo_pkg::*;
#(
   parameter int                      DATA_WIDTH   = 10,
   parameter int                      BUFFER_DEPTH = 8,
   parameter logic [BUFFER_DEPTH-1:0] RESET_VALUE  = BUFFER_DEPTH'(TOK_RESET)
)(
   input  logic                    clk,
   input  logic                    rstn,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    valid,
   input  logic                    ready,
   input  logic [BUFFER_DEPTH-1:0] write_token,
   output logic [BUFFER_DEPTH-1:0] read_pointer,
   input  logic [DATA_WIDTH-1:0]   data_async
);

   logic [BUFFER_DEPTH-1:0] w_sync_token;
   logic [BUFFER_DEPTH-1:0] w_sync_wptr;
   logic [BUFFER_DEPTH-1:0] w_read_tok;
   logic [BUFFER_DEPTH-1:0] w_read_ptr;
   logic                    w_empty;
   logic                    w_pop;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_valid;

   dc_token_synchronizer #(
      .WIDTH      (BUFFER_DEPTH),
      .DEPTH      (SYNC_DEPTH),
      .RESET_VALUE(RESET_VALUE)
   ) u_wtok_sync (
      .clk    (clk),
      .rstn   (rstn),
      .i_async(write_token),
      .o_sync (w_sync_token)
   );

   dc_token_ring #(
      .WIDTH      (BUFFER_DEPTH),
      .RESET_VALUE(RESET_VALUE)
   ) u_rd_ring (
      .clk    (clk),
      .rstn   (rstn),
      .i_adv  (w_pop),
      .o_token(w_read_tok)
   );

   assign w_sync_wptr = BUFFER_DEPTH'(ptr_from_tok(TOK_MAX_W'(w_sync_token), BUFFER_DEPTH));
   assign w_read_ptr  = BUFFER_DEPTH'(ptr_from_tok(TOK_MAX_W'(w_read_tok), BUFFER_DEPTH));

   // A zero pointer means the synced token is mid-move; treat it as empty rather than guess.
   assign w_empty = (w_sync_wptr == '0) || (w_sync_wptr == w_read_ptr);
   assign w_pop   = !w_empty && (!r_valid || ready);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (w_pop) begin
         r_data  <= data_async;
         r_valid <= 1'b1;
      end else if (ready) begin
         r_valid <= 1'b0;
      end
   end

   assign data         = r_data;
   assign valid        = r_valid;
   assign read_pointer = w_read_ptr;

endmodule

// File: tb/tb_dc_token_ring_fifo_dout.sv
// Bench for the read half: emulates the write side and slot memory, checks against an in-order queue model.
module tb_dc_token_ring_fifo_dout;

   localparam int DW = 10;
   localparam int D  = 8;
`ifdef DC_TOKEN_RING_SYNC3_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] data;
   logic          valid;
   logic          ready = 1'b0;
   logic [D-1:0]  write_token = 8'hc;
   logic [D-1:0]  read_pointer;
   logic [DW-1:0] data_async;

   logic [DW-1:0] mem [D];
   logic [DW-1:0] exp_q [$];
   int vectors = 0;
   int miscompares = 0;
   int widx = 3;
   int ptr_idx = 3;
   int n_xfer = 0;

   always #5 clk = ~clk;

   dc_token_ring_fifo_dout #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .RESET_VALUE(8'hc)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .write_token (write_token),
      .read_pointer(read_pointer),
      .data_async  (data_async)
   );

   // Buffer read mux: the slot named by the one-hot read_pointer.
   always_comb begin
      data_async = '0;
      for (int i = 0; i < D; i++)
         if (read_pointer[i]) data_async = mem[i];
   end

   task automatic write_word(input logic [DW-1:0] w);
      mem[widx] = w;
      exp_q.push_back(w);
      widx = (widx + 1) % D;
      write_token = D'((1 << widx) | (1 << ((widx + D - 1) % D)));
   endtask

   // One clock: score any output transfer, then track read_pointer steps around the ring.
   task automatic tick();
      logic [DW-1:0] ew;
      int nxt;
      if (valid === 1'b1 && ready === 1'b1) begin
         vectors++;
         n_xfer++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL xfer_spurious got data=%h, required no transfer", data);
         end else begin
            ew = exp_q.pop_front();
            if (data !== ew) begin
               miscompares++;
               $display("FAIL xfer_data got %h, required %h", data, ew);
            end
         end
      end
      @(posedge clk);
      #1;
      if (read_pointer !== D'(1 << ptr_idx)) begin
         nxt = (ptr_idx + 1) % D;
         vectors++;
         if (read_pointer !== D'(1 << nxt)) begin
            miscompares++;
            $display("FAIL ptr_step got %h, required %h", read_pointer, D'(1 << nxt));
         end
         ptr_idx = nxt;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      ready = 1'b0;
      write_token = 8'hc;
      widx = 3;
      ptr_idx = 3;
      exp_q.delete();
      for (int i = 0; i < D; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b, required 0", valid); end
      vectors++;
      if (read_pointer !== 8'h08) begin miscompares++; $display("FAIL reset_ptr got %h, required 08", read_pointer); end
      vectors++;
      if (data !== '0) begin miscompares++; $display("FAIL reset_data got %h, required 000", data); end
      for (int c = 0; c < 20; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b0 || read_pointer !== 8'h08) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d got valid=%b ptr=%h, required 0/08", c, valid, read_pointer);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      write_word(10'h155);
      for (int e = 1; e <= LAT; e++) begin
         tick();
         vectors++;
         if (valid !== (e == LAT)) begin
            miscompares++;
            $display("FAIL single_latency edge %0d got valid=%b, required %b", e, valid, (e == LAT));
         end
      end
      vectors++;
      if (data !== 10'h155) begin miscompares++; $display("FAIL single_data got %h, required 155", data); end
      vectors++;
      if (read_pointer !== 8'h10) begin miscompares++; $display("FAIL single_ptr got %h, required 10", read_pointer); end
      ready = 1'b1;
      tick();
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got valid=%b, required 0", valid); end
      ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] w0;
      int x0;
      do_reset();
      w0 = DW'($urandom_range(0, 1023));
      write_word(w0);
      tick();
      write_word(DW'($urandom_range(0, 1023)));
      tick();
      write_word(DW'($urandom_range(0, 1023)));
      repeat (LAT + 1) tick();
      for (int c = 0; c < 10; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b1 || data !== w0 || read_pointer !== 8'h10) begin
            miscompares++;
            $display("FAIL bp_hold cycle %0d got valid=%b data=%h ptr=%h, required 1/%h/10", c, valid, data, read_pointer, w0);
         end
      end
      ready = 1'b1;
      x0 = n_xfer;
      for (int k = 1; k <= 3; k++) begin
         tick();
         vectors++;
         if (n_xfer - x0 !== k) begin
            miscompares++;
            $display("FAIL bp_burst after %0d cycles got %0d words, required %0d", k, n_xfer - x0, k);
         end
      end
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got valid=%b, required 0", valid); end
      ready = 1'b0;
   endtask

   // Random writes bounded by free space; ready either held high or randomised.
   task automatic run_stream(input int nwords, input bit rand_ready, input string tag);
      int written, x0, cyc;
      logic          pv, pr;
      logic [DW-1:0] pd;
      do_reset();
      written = 0;
      x0 = n_xfer;
      cyc = 0;
      ready = 1'b1;
      while ((n_xfer - x0) < nwords && cyc < 2000) begin
         if (written < nwords && (written - (n_xfer - x0)) < 6 && $urandom_range(0, 3) != 0) begin
            write_word(DW'($urandom_range(0, 1023)));
            written++;
         end
         if (rand_ready) ready = 1'($urandom_range(0, 1));
         pv = valid; pr = ready; pd = data;
         tick();
         if (pv === 1'b1 && pr === 1'b0) begin
            vectors++;
            if (valid !== 1'b1 || data !== pd) begin
               miscompares++;
               $display("FAIL %s_stall got valid=%b data=%h, required 1/%h", tag, valid, data, pd);
            end
         end
         cyc++;
      end
      vectors++;
      if (n_xfer - x0 !== nwords || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_count got %0d words (%0d left), required %0d", tag, n_xfer - x0, exp_q.size(), nwords);
      end
      vectors++;
      if (read_pointer !== D'(1 << ((3 + nwords) % D))) begin
         miscompares++;
         $display("FAIL %s_final_ptr got %h, required %h", tag, read_pointer, D'(1 << ((3 + nwords) % D)));
      end
      ready = 1'b0;
   endtask

   task automatic test_wrap();
      run_stream(20, 1'b0, "wrap");
   endtask

   task automatic test_back_to_back();
      run_stream(40, 1'b1, "random");
   endtask

   task automatic test_transient();
      logic [DW-1:0] w;
      int x0;
      do_reset();
      ready = 1'b1;
      x0 = n_xfer;
      w = DW'($urandom_range(0, 1023));
      mem[3] = w;
      exp_q.push_back(w);
      write_token = 8'h08;
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++;
         if (valid !== 1'b0 || read_pointer !== 8'h08) begin
            miscompares++;
            $display("FAIL transient_hold cycle %0d got valid=%b ptr=%h, required 0/08", c, valid, read_pointer);
         end
      end
      write_token = 8'h18;
      widx = 4;
      repeat (LAT + 3) tick();
      vectors++;
      if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL transient_count got %0d words, required 1", n_xfer - x0); end
      vectors++;
      if (read_pointer !== 8'h10) begin miscompares++; $display("FAIL transient_ptr got %h, required 10", read_pointer); end
      ready = 1'b0;
   endtask

   task automatic test_reset_async();
      do_reset();
      write_word(DW'($urandom_range(0, 1023)));
      tick();
      write_word(DW'($urandom_range(0, 1023)));
      tick();
      write_word(DW'($urandom_range(0, 1023)));
      repeat (LAT + 1) tick();
      vectors++;
      if (valid !== 1'b1) begin miscompares++; $display("FAIL arst_setup got valid=%b, required 1", valid); end
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b, required 0", valid); end
      vectors++;
      if (read_pointer !== 8'h08) begin miscompares++; $display("FAIL arst_ptr got %h, required 08", read_pointer); end
      vectors++;
      if (data !== '0) begin miscompares++; $display("FAIL arst_data got %h, required 000", data); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_wrap();
      test_transient();
      test_back_to_back();
      test_reset_async();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0t, required completion", $time);
      $fatal(1);
   end

endmodule
